// File: rtl/s_pea_out_buffer.sv
// s_pea_out_buffer: captures PE results once, buffers them in a FIFO and streams them out with PEA backpressure.
// Optional element counter (m_last_o/done_o) is built when S_PEA_OUT_BUF_LAST_EN is defined.
module s_pea_out_buffer #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mage_done_i,
    input  logic              start_i,
    input  logic [15:0]       cfg_n_elems_i,
    input  logic [N_BITS-1:0] pe_res_i,
    input  logic              pe_valid_i,
    output logic              pea_ready_o,
    output logic [N_BITS-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              done_o,
    output logic              ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr, rptr, count;
    logic [N_BITS-1:0] mem [DEPTH];
    logic              rdy_q, push, pop, full;

    assign count       = wptr - rptr;
    assign full        = count == (AW+1)'(DEPTH);
    // Two free slots: one for the push that may already be in flight.
    assign pea_ready_o = count <= (AW+1)'(DEPTH - 2);
    assign m_valid_o   = count != '0;
    assign m_data_o    = m_valid_o ? mem[rptr[AW-1:0]] : '0;
    // The PE holds its result while stalled, so only take it if we were ready last cycle.
    assign push        = pe_valid_i && rdy_q;
    assign pop         = m_valid_o && m_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            rdy_q <= 1'b0;
        end else if (mage_done_i) begin
            wptr  <= '0;
            rptr  <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= pea_ready_o;
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wptr[AW-1:0]] <= pe_res_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_o <= 1'b0;
        else if (push && full) ovf_o <= 1'b1;
        else if (start_i && !mage_done_i) ovf_o <= 1'b0;
    end

`ifdef S_PEA_OUT_BUF_LAST_EN
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t      state, state_n;
    logic [15:0] remaining, remaining_n;
    logic        done_n;

    assign m_last_o = (state == RUN) && (remaining == 16'd1) && m_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            done_o    <= done_n;
        end
    end

    // remaining == 0 means unbounded: it never decrements, so it never reaches 1.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        done_n      = 1'b0;
        if (mage_done_i) begin
            state_n = IDLE;
        end else if (start_i) begin
            state_n     = RUN;
            remaining_n = cfg_n_elems_i;
        end else if (state == LAST) begin
            state_n = IDLE;
        end else if (state == RUN && pop) begin
            if (m_last_o) begin
                state_n = LAST;
                done_n  = 1'b1;
            end
            if (remaining != '0) remaining_n = remaining - 16'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^cfg_n_elems_i;
    assign m_last_o   = 1'b0;
    assign done_o     = 1'b0;
`endif

endmodule

// File: tb/tb_s_pea_out_buffer.sv
// tb_s_pea_out_buffer: directed and random stimulus against a queue-based reference model of s_pea_out_buffer.
module tb_s_pea_out_buffer;
    localparam int D = 8;
`ifdef S_PEA_OUT_BUF_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, mage_done = 1'b0, start = 1'b0;
    logic        pe_valid = 1'b0, m_ready = 1'b0;
    logic [15:0] cfg = '0;
    logic [31:0] pe_res = '0;
    logic        pea_ready, m_valid, m_last, done, ovf;
    logic [31:0] m_data;

    s_pea_out_buffer #(.N_BITS(32), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .mage_done_i(mage_done), .start_i(start),
        .cfg_n_elems_i(cfg), .pe_res_i(pe_res), .pe_valid_i(pe_valid),
        .pea_ready_o(pea_ready), .m_data_o(m_data), .m_valid_o(m_valid),
        .m_last_o(m_last), .m_ready_i(m_ready), .done_o(done), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    logic [31:0] q[$];
    bit          m_rdy, m_ovf, m_run, m_done;
    int          m_rem;
    logic [31:0] pe_cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy  = 1'b0;
        m_ovf  = 1'b0;
        m_run  = 1'b0;
        m_rem  = 0;
        m_done = 1'b0;
    endtask

    task automatic check_all();
        bit v;
        v = q.size() != 0;
        chk("pea_ready", {31'b0, pea_ready}, {31'b0, (D - q.size()) >= 2});
        chk("m_valid", {31'b0, m_valid}, {31'b0, v});
        chk("m_data", m_data, v ? q[0] : 32'h0);
        chk("m_last", {31'b0, m_last}, {31'b0, LAST_EN && m_run && m_rem == 1 && v});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    // One cycle: check outputs, drive inputs, advance the model, clock.
    task automatic step(input bit pv, input logic [31:0] pd, input bit mr, input bit st,
                        input bit fl, input logic [15:0] c, input bit frc = 1'b0);
        bit rdy_now, valid, lst, psh, pp, full;
        check_all();
        pe_valid = pv; pe_res = pd; m_ready = mr; start = st; mage_done = fl; cfg = c;
        rdy_now = (D - q.size()) >= 2;
        valid   = q.size() != 0;
        lst     = LAST_EN && m_run && m_rem == 1 && valid;
        psh     = pv && (m_rdy || frc);
        pp      = valid && mr;
        full    = q.size() == D;
        if (fl) begin
            q.delete();
            m_rdy  = 1'b0;
            m_run  = 1'b0;
            m_done = 1'b0;
            if (psh && full) m_ovf = 1'b1;
        end else begin
            m_done = pp && lst && !st;
            if (pp) void'(q.pop_front());
            if (psh) begin
                if (full) m_ovf = 1'b1;
                else q.push_back(pd);
            end
            m_rdy = rdy_now;
            if (st) begin
                if (!(psh && full)) m_ovf = 1'b0;
                m_run = LAST_EN;
                m_rem = c;
            end else if (pp && m_run) begin
                if (lst) m_run = 1'b0;
                if (m_rem != 0) m_rem--;
            end
        end
        if (frc) force dut.rdy_q = 1'b1;
        @(posedge clk);
        if (frc) release dut.rdy_q;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        pe_cur = 32'h0;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 0, 0);
        // basic stream
        step(1, 32'h11, 1, 0, 0, 0);
        step(1, 32'h22, 1, 0, 0, 0);
        step(1, 32'h33, 1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        // stall with a PE that holds its result while not ready
        for (int i = 0; i < 12; i++) begin
            if (m_rdy) pe_cur = 32'h100 + i;
            step(1, pe_cur, 0, 0, 0, 0);
        end
        repeat (10) step(0, 0, 1, 0, 0, 0);
        // overflow: fill, then force a capture while full
        for (int i = 0; i < 20 && q.size() < D; i++) step(1, 32'h200 + i, 0, 0, 0, 0);
        step(1, 32'hdead, 0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        repeat (10) step(0, 0, 1, 0, 0, 0);
        // last/done with 4 elements, then extra elements
        step(0, 0, 1, 1, 0, 16'd4);
        for (int i = 0; i < 6; i++) step(1, 32'h300 + i, 1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        // last/done with the sink stalling
        step(0, 0, 0, 1, 0, 16'd3);
        for (int i = 0; i < 4; i++) step(1, 32'h380 + i, 0, 0, 0, 0);
        repeat (6) step(0, 0, 1, 0, 0, 0);
        // flush with 3 entries buffered
        for (int i = 0; i < 3; i++) step(1, 32'h400 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 1, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_rdy) pe_cur = $urandom;
            step($urandom_range(0, 3) != 0, pe_cur, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
                 16'($urandom_range(0, 6)));
        end
        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) step(1, 32'h500 + i, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 0, 0);
        step(1, 32'h600, 1, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0, 0);
        check_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
